// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: decoded hazard inputs from ID/EX/MEM
// and the stall/flush/redirect strobes back to the pipeline registers.
// master = pipeline side, slave = hazard controller.
interface hazard_ctrl_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic [4:0] ex_rd;
  logic       ex_mem_read;
  logic       ex_redirect;
  logic       mem_req;
  logic       mem_ready;
  logic       pc_stall;
  logic       ifid_stall;
  logic       ifid_flush;
  logic       idex_stall;
  logic       idex_flush;
  logic       exmem_stall;
  logic       memwb_bubble;
  logic       pc_redirect;
  logic       busy;
  logic       mem_timeout;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_redirect, mem_req, mem_ready,
    input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
           exmem_stall, memwb_bubble, pc_redirect, busy, mem_timeout
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_redirect, mem_req, mem_ready,
    output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
           exmem_stall, memwb_bubble, pc_redirect, busy, mem_timeout
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/redirect sequencer for the 5-stage core.
// Resolves data-memory waits (with timeout), load-use and control hazards.
// Optional macro HAZARD_PERF_CNT_EN adds saturating perf counters and perf_clr.
//
// state    | meaning
// RUN      | normal flow; a memstall here freezes the pipe and enters MEM_WAIT
// MEM_WAIT | data memory access outstanding; wait_cnt counts frozen cycles
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  hazard_ctrl_if.slave    hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  input  logic            perf_clr,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] lu_stalls,
  output logic [CNT_W-1:0] flushes
`endif
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(MEM_TIMEOUT);

  if (MEM_TIMEOUT < 1) begin : g_bad_timeout
    $error("hazard_ctrl: MEM_TIMEOUT must be >= 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("hazard_ctrl: CNT_W must be >= 1");
  end

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;
  logic          timeout_q, timeout_set;
  logic          at_limit, memstall, luhaz, do_redirect, do_lu;

  // hazard detection and priority resolution
  always_comb begin
    at_limit    = (state == MEM_WAIT) && (wait_cnt == TMO);
    memstall    = hz.mem_req & ~hz.mem_ready & ~at_limit;
    luhaz       = hz.ex_mem_read & (hz.ex_rd != 5'd0) &
                  ((hz.id_uses_rs1 & (hz.id_rs1 == hz.ex_rd)) |
                   (hz.id_uses_rs2 & (hz.id_rs2 == hz.ex_rd)));
    // a redirect kills the ID instruction, so its load-use hazard is moot
    do_redirect = ~memstall & hz.ex_redirect;
    do_lu       = ~memstall & ~hz.ex_redirect & luhaz;
  end

  assign hz.pc_stall     = memstall | do_lu;
  assign hz.ifid_stall   = memstall | do_lu;
  assign hz.ifid_flush   = do_redirect;
  assign hz.idex_stall   = memstall;
  assign hz.idex_flush   = do_redirect | do_lu;
  assign hz.exmem_stall  = memstall;
  assign hz.memwb_bubble = memstall;
  assign hz.pc_redirect  = do_redirect;
  assign hz.busy         = (state == MEM_WAIT);
  assign hz.mem_timeout  = timeout_q;

  // next-state and wait counter
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    timeout_set  = 1'b0;
    case (state)
      RUN: begin
        if (memstall) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = CW'(1);
        end
      end
      MEM_WAIT: begin
        // mem_req dropping mid-wait is illegal; treat it as a release
        if (!hz.mem_req || hz.mem_ready) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (at_limit) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
          timeout_set  = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + CW'(1);
        end
      end
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  // state, counter and sticky timeout registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      if (timeout_set) timeout_q <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      lu_stalls    <= '0;
      flushes      <= '0;
    end else if (perf_clr) begin
      stall_cycles <= '0;
      lu_stalls    <= '0;
      flushes      <= '0;
    end else begin
      if (memstall && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_W'(1);
      if (do_lu && (lu_stalls != '1))       lu_stalls    <= lu_stalls + CNT_W'(1);
      if (do_redirect && (flushes != '1))   flushes      <= flushes + CNT_W'(1);
    end
  end
`endif

endmodule
